// File: rtl/mult_arbiter.sv
// mult_arbiter: round-robin arbiter that lets REQS requesters share one
// signed N x N array multiplier.
//
// Build option: define MULT_ARBITER_PIPE_EN to add a CALC2 state. CALC then
// only captures the multiplier output and CALC2 moves it to res_data/res_id.
// This adds one cycle of latency and shortens the multiplier-to-output path.
//
// Ports
//   clk        : single clock, rising edge
//   rst_n      : synchronous active-low reset
//   req_valid  : per-requester operand valid            [REQS]
//   req_ready  : per-requester accept, one-hot or zero  [REQS]
//   req_a      : operand A, requester k at [k*N +: N]   [REQS*N]
//   req_b      : operand B, requester k at [k*N +: N]   [REQS*N]
//   res_valid  : result available
//   res_ready  : result consumer accept
//   res_data   : full-width signed product A*B          [2N]
//   res_id     : index of the requester owning res_data [IDW]
//   busy       : high whenever the FSM is not in IDLE

// Signed array multiplier. It forms one sign-extended partial-product row
// per bit of b. The MSB row has negative weight in two's complement, so it
// is subtracted instead of added.
module mult_arbiter_smul #(
  parameter int N = 5
) (
  input  logic signed [N-1:0]   a,
  input  logic signed [N-1:0]   b,
  output logic signed [2*N-1:0] p
);

  logic signed [2*N-1:0] a_ext;
  logic signed [2*N-1:0] row [N];

  assign a_ext = {{N{a[N-1]}}, a};

  for (genvar i = 0; i < N; i++) begin : g_row
    assign row[i] = b[i] ? (a_ext <<< i) : '0;
  end

  always_comb begin
    p = '0;
    for (int i = 0; i < N - 1; i++) p = p + row[i];
    p = p - row[N-1];
  end

endmodule

module mult_arbiter #(
  parameter int N    = 5,
  parameter int REQS = 4,
  parameter int IDW  = $clog2(REQS)
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic [REQS-1:0]       req_valid,
  output logic [REQS-1:0]       req_ready,
  input  logic [REQS*N-1:0]     req_a,
  input  logic [REQS*N-1:0]     req_b,
  output logic                  res_valid,
  input  logic                  res_ready,
  output logic [2*N-1:0]        res_data,
  output logic [IDW-1:0]        res_id,
  output logic                  busy
);

`ifdef MULT_ARBITER_PIPE_EN
  typedef enum logic [1:0] {S_IDLE, S_CALC, S_CALC2, S_DONE} state_t;
`else
  typedef enum logic [1:0] {S_IDLE, S_CALC, S_DONE} state_t;
`endif

  state_t                state;
  logic [IDW-1:0]        rr_ptr;
  logic signed [N-1:0]   a_p0;
  logic signed [N-1:0]   b_p0;
  logic [IDW-1:0]        id_p0;
  logic signed [2*N-1:0] prod;
`ifdef MULT_ARBITER_PIPE_EN
  logic signed [2*N-1:0] prod_p1;
`endif

  // Arbitration results
  logic                  found;
  logic [REQS-1:0]       gnt;
  logic [IDW-1:0]        gnt_id;
  logic [IDW-1:0]        idx;
  logic signed [N-1:0]   a_sel;
  logic signed [N-1:0]   b_sel;
  logic [IDW-1:0]        rr_next;

  // Round-robin search starting at rr_ptr. A grant is only offered in IDLE
  // and never while reset is asserted. Because req_ready is gated by
  // req_valid, any grant is a handshake.
  always_comb begin
    found  = 1'b0;
    gnt    = '0;
    gnt_id = '0;
    idx    = '0;
    a_sel  = '0;
    b_sel  = '0;
    if (state == S_IDLE && rst_n) begin
      for (int k = 0; k < REQS; k++) begin
        idx = IDW'((int'(rr_ptr) + k) % REQS);
        if (!found && req_valid[idx]) begin
          found       = 1'b1;
          gnt[idx]    = 1'b1;
          gnt_id      = idx;
          a_sel       = req_a[int'(idx)*N +: N];
          b_sel       = req_b[int'(idx)*N +: N];
        end
      end
    end
  end

  assign req_ready = gnt;
  assign rr_next   = (gnt_id == IDW'(REQS - 1)) ? '0 : gnt_id + IDW'(1);

  mult_arbiter_smul #(.N(N)) u_mul (
    .a (a_p0),
    .b (b_p0),
    .p (prod)
  );

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state     <= S_IDLE;
      rr_ptr    <= '0;
      a_p0      <= '0;
      b_p0      <= '0;
      id_p0     <= '0;
      res_valid <= 1'b0;
      res_data  <= '0;
      res_id    <= '0;
      busy      <= 1'b0;
`ifdef MULT_ARBITER_PIPE_EN
      prod_p1   <= '0;
`endif
    end else begin
      case (state)
        // p0: capture the granted operands so later input changes cannot
        // disturb the operation
        S_IDLE: begin
          if (found) begin
            a_p0   <= a_sel;
            b_p0   <= b_sel;
            id_p0  <= gnt_id;
            rr_ptr <= rr_next;
            busy   <= 1'b1;
            state  <= S_CALC;
          end
        end
`ifdef MULT_ARBITER_PIPE_EN
        // p1: register the multiplier output
        S_CALC: begin
          prod_p1 <= prod;
          state   <= S_CALC2;
        end
        S_CALC2: begin
          res_data  <= prod_p1;
          res_id    <= id_p0;
          res_valid <= 1'b1;
          state     <= S_DONE;
        end
`else
        // p1: the multiplier output goes straight to the result registers
        S_CALC: begin
          res_data  <= prod;
          res_id    <= id_p0;
          res_valid <= 1'b1;
          state     <= S_DONE;
        end
`endif
        S_DONE: begin
          if (res_ready) begin
            res_valid <= 1'b0;
            busy      <= 1'b0;
            state     <= S_IDLE;
          end
        end
        default: state <= S_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_mult_arbiter.sv
module tb_mult_arbiter;

  localparam int N    = 5;
  localparam int REQS = 4;
  localparam int IDW  = 2;
`ifdef MULT_ARBITER_PIPE_EN
  localparam int LAT  = 3;
`else
  localparam int LAT  = 2;
`endif

  logic                clk = 1'b0;
  logic                rst_n = 1'b0;
  logic [REQS-1:0]     req_valid = '0;
  logic [REQS-1:0]     req_ready;
  logic [REQS*N-1:0]   req_a = '0;
  logic [REQS*N-1:0]   req_b = '0;
  logic                res_valid;
  logic                res_ready = 1'b1;
  logic [2*N-1:0]      res_data;
  logic [IDW-1:0]      res_id;
  logic                busy;

  int n_cmp = 0;
  int n_err = 0;
  int cyc   = 0;

  mult_arbiter #(.N(N), .REQS(REQS)) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .req_valid (req_valid),
    .req_ready (req_ready),
    .req_a     (req_a),
    .req_b     (req_b),
    .res_valid (res_valid),
    .res_ready (res_ready),
    .res_data  (res_data),
    .res_id    (res_id),
    .busy      (busy)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  task automatic check(input string nm, input logic [63:0] act, input logic [63:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h, expected %0h (cycle %0d)", nm, act, exp, cyc);
    end
  endtask

  // ---------------- behavioural model ----------------
  bit     m_init  = 0;
  bit     m_idle  = 1;
  bit     m_valid = 0;
  int     m_rr = 0, m_cnt = 0, m_pid = 0, m_id = 0;
  longint m_pdata = 0, m_data = 0;

  function automatic int pick(input logic [REQS-1:0] v, input int rr);
    for (int k = 0; k < REQS; k++) begin
      if (v[(rr + k) % REQS]) return (rr + k) % REQS;
    end
    return -1;
  endfunction

  function automatic int opnd(input logic [REQS*N-1:0] bus, input int k);
    logic signed [N-1:0] x;
    x = bus[k*N +: N];
    return int'(x);
  endfunction

  always @(posedge clk) begin
    int g;
    if (!rst_n) begin
      m_init = 1; m_idle = 1; m_valid = 0; m_rr = 0; m_cnt = 0;
      m_data = 0; m_id = 0;
    end else if (m_idle) begin
      g = pick(req_valid, m_rr);
      if (g >= 0) begin
        m_idle  = 0;
        m_cnt   = 1;
        m_pdata = longint'(opnd(req_a, g) * opnd(req_b, g));
        m_pid   = g;
        m_rr    = (g + 1) % REQS;
      end
    end else if (!m_valid) begin
      m_cnt++;
      if (m_cnt == LAT) begin
        m_valid = 1; m_data = m_pdata; m_id = m_pid;
      end
    end else if (res_ready) begin
      m_valid = 0; m_idle = 1;
    end
  end

  always @(negedge clk) begin
    logic [REQS-1:0] exp_rdy;
    logic [2*N-1:0]  ed;
    int g;
    if (m_init) begin
      exp_rdy = '0;
      if (m_idle && rst_n) begin
        g = pick(req_valid, m_rr);
        if (g >= 0) exp_rdy[g] = 1'b1;
      end
      check("req_ready", 64'(req_ready), 64'(exp_rdy));
      check("res_valid", 64'(res_valid), 64'(m_valid));
      check("busy", 64'(busy), 64'(!m_idle));
      if (m_valid) begin
        ed = m_data[2*N-1:0];
        check("res_data", 64'(res_data), 64'(ed));
        check("res_id", 64'(res_id), 64'(m_id));
      end
    end
  end

  // ---------------- directed stimulus ----------------
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic set_op(input int k, input int a, input int b);
    req_a[k*N +: N] = N'(a);
    req_b[k*N +: N] = N'(b);
  endtask

  task automatic do_req(input int k, input int a, input int b,
                        output int lat, output logic [2*N-1:0] d, output logic [IDW-1:0] id);
    int acc_c;
    tick();
    set_op(k, a, b);
    req_valid[k] = 1'b1;
    acc_c = -1; lat = -1; d = '0; id = '0;
    for (int i = 0; i < 20; i++) begin
      @(negedge clk);
      if (req_ready[k]) begin acc_c = cyc; break; end
    end
    tick();
    req_valid[k] = 1'b0;
    if (acc_c < 0) begin
      check("accept_timeout", 64'(0), 64'(1));
      return;
    end
    for (int i = 0; i < 20; i++) begin
      @(negedge clk);
      if (res_valid) begin lat = cyc - acc_c; d = res_data; id = res_id; break; end
    end
    if (lat < 0) check("result_timeout", 64'(0), 64'(1));
  endtask

  initial begin
    int lat;
    logic [2*N-1:0] d;
    logic [IDW-1:0] id;
    int gnt[5], gcy[5], rid[4];
    int ng, nr;
    bit ok;

    // Reset: outputs cleared and no grant even with every request asserted
    rst_n = 1'b0; req_valid = '1; res_ready = 1'b1;
    repeat (3) tick();
    @(negedge clk);
    check("rst_res_valid", 64'(res_valid), 64'(0));
    check("rst_res_data", 64'(res_data), 64'(0));
    check("rst_res_id", 64'(res_id), 64'(0));
    check("rst_busy", 64'(busy), 64'(0));
    check("rst_req_ready", 64'(req_ready), 64'(0));
    tick(); req_valid = '0;
    tick(); rst_n = 1'b1;

    // 3 * -4 from requester 1
    do_req(1, 3, -4, lat, d, id);
    check("r1_data", 64'(d), 64'(10'h3F4));
    check("r1_id", 64'(id), 64'(1));
    check("r1_latency", 64'(lat), 64'(LAT));
    tick(); @(negedge clk);
    check("r1_valid_one_cycle", 64'(res_valid), 64'(0));

    // extreme operands on requester 0
    do_req(0, -16, -16, lat, d, id);
    check("min_min_data", 64'(d), 64'(10'h100));
    check("min_min_id", 64'(id), 64'(0));
    do_req(0, -16, 15, lat, d, id);
    check("min_max_data", 64'(d), 64'(10'h310));

    // all requesters active: rotation 0,1,2,3,0, one grant per LAT+1 cycles
    tick(); rst_n = 1'b0;
    tick(); rst_n = 1'b1;
    for (int k = 0; k < REQS; k++) set_op(k, k + 1, -(k + 2));
    req_valid = '1;
    ng = 0; nr = 0;
    for (int i = 0; i < 60 && ng < 5; i++) begin
      @(negedge clk);
      for (int k = 0; k < REQS; k++) begin
        if (req_ready[k] && req_valid[k]) begin gnt[ng] = k; gcy[ng] = cyc; ng++; end
      end
      if (res_valid && res_ready && nr < 4) begin rid[nr] = int'(res_id); nr++; end
    end
    tick(); req_valid = '0;
    check("rr_grant_count", 64'(ng), 64'(5));
    check("rr_result_count", 64'(nr), 64'(4));
    if (ng == 5) begin
      for (int i = 0; i < 5; i++) check("rr_order", 64'(gnt[i]), 64'(i % REQS));
      for (int i = 1; i < 5; i++) check("rr_spacing", 64'(gcy[i] - gcy[i-1]), 64'(LAT + 1));
    end
    if (nr == 4) for (int i = 0; i < 4; i++) check("rr_res_id", 64'(rid[i]), 64'(i));

    // back-pressure: result held for 5 cycles with other requests pending
    repeat (LAT + 2) tick();
    res_ready = 1'b0;
    do_req(2, 7, 5, lat, d, id);
    check("bp_first_data", 64'(d), 64'(10'h023));
    tick(); req_valid[0] = 1'b1;
    ok = 1;
    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      check("bp_valid", 64'(res_valid), 64'(1));
      check("bp_data", 64'(res_data), 64'(10'h023));
      check("bp_id", 64'(res_id), 64'(2));
      check("bp_req_ready", 64'(req_ready), 64'(0));
      check("bp_busy", 64'(busy), 64'(1));
      tick();
    end
    res_ready = 1'b1; req_valid[0] = 1'b0;
    @(negedge clk);
    check("bp_accept_cycle_valid", 64'(res_valid), 64'(1));
    tick(); @(negedge clk);
    check("bp_released", 64'(res_valid), 64'(0));

    // reset while the multiplier is working
    tick();
    set_op(3, 5, 5);
    req_valid[3] = 1'b1;
    ok = 0;
    for (int i = 0; i < 20; i++) begin
      @(negedge clk);
      if (req_ready[3]) begin ok = 1; break; end
    end
    check("calc_rst_accept", 64'(ok), 64'(1));
    tick(); req_valid[3] = 1'b0; rst_n = 1'b0;
    tick(); rst_n = 1'b1;
    @(negedge clk);
    check("calc_rst_valid", 64'(res_valid), 64'(0));
    check("calc_rst_busy", 64'(busy), 64'(0));
    for (int i = 0; i < 8; i++) begin
      tick(); @(negedge clk);
      check("no_stale_result", 64'(res_valid), 64'(0));
    end
    tick(); req_valid = 4'b0011;
    @(negedge clk);
    check("rr_ptr_after_reset", 64'(req_ready), 64'(4'b0001));
    tick(); req_valid = '0;
    repeat (8) tick();

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL global_timeout: simulation did not finish");
    $fatal(1);
  end

endmodule
